// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic signal controller request path.
package traffic_pkg;

  localparam int unsigned PHASE_W = 4;
  localparam logic [PHASE_W-1:0] PHASE_HOLD = 4'd0;
  localparam logic [PHASE_W-1:0] PHASE_LAST = 4'd12;

  // Width of the press counter and the idle wait counter
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } req_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and counter debouncer for the request button;
// press_c pulses for one clock on the edge where the debounced level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn_raw_i,
  output logic press_c
);

  localparam int unsigned DB_W = 4;

  logic            s1_q;
  logic            s2_q;
  logic            stable_q;
  logic            stable_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Level changes only once the disagreement has lasted the full count
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_c  = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
        stable_d = s2_q;
        press_c  = s2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_request_ctrl.sv
// Request latch in front of the traffic signal controller: one request per light cycle.
// Optional idle auto-request enabled by defining TRAFFIC_REQ_TIMEOUT_EN.
module traffic_request_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT        = 26
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               btn_raw,
  input  logic [PHASE_W-1:0] q,
  output logic               switch,
  output logic               req_led,
  output logic [CNT_W-1:0]   press_count
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..15");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("MAX_WAIT must be in 1..255");
  end

  req_state_e         state_q;
  req_state_e         state_d;
  logic               next_q;
  logic               next_d;
  logic [PHASE_W-1:0] q_prev_q;
  logic               switch_q;
  logic               switch_d;
  logic               req_led_q;
  logic               req_led_d;
  logic [CNT_W-1:0]   press_count_q;
  logic [CNT_W-1:0]   press_count_d;
  logic               press_c;
  logic               timeout_c;
  logic               leave_hold_c;
  logic               at_hold_c;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock    (clock),
    .resetn   (resetn),
    .btn_raw_i(btn_raw),
    .press_c  (press_c)
  );

`ifdef TRAFFIC_REQ_TIMEOUT_EN
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_d;

  // Idle time runs only while nothing is requested; leaving IDLE restarts it
  assign timeout_c = (state_q == IDLE) && (wait_q == CNT_W'(MAX_WAIT - 1));
  assign wait_d    = ((state_q == IDLE) && !press_c && !timeout_c) ? wait_q + CNT_W'(1) : '0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  assign leave_hold_c = (q_prev_q == PHASE_HOLD) && (q != PHASE_HOLD);
  assign at_hold_c    = (q == PHASE_HOLD);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      next_q        <= 1'b0;
      q_prev_q      <= '0;
      switch_q      <= 1'b0;
      req_led_q     <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      next_q        <= next_d;
      q_prev_q      <= q;
      switch_q      <= switch_d;
      req_led_q     <= req_led_d;
      press_count_q <= press_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    next_d        = next_q;
    press_count_d = press_count_q;

    if (press_c && (press_count_q != '1)) begin
      press_count_d = press_count_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (press_c || timeout_c) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (leave_hold_c) begin
          state_d = SERVING;
          next_d  = next_q | press_c;
        end
      end
      SERVING: begin
        // Back at the hold point: a latched or coincident press starts the next cycle
        if (at_hold_c) begin
          state_d = (next_q || press_c) ? PENDING : IDLE;
          next_d  = 1'b0;
        end else if (press_c) begin
          next_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        next_d  = 1'b0;
      end
    endcase

    switch_d  = (state_d == PENDING);
    req_led_d = (state_d != IDLE) || next_d;
  end

  assign switch      = switch_q;
  assign req_led     = req_led_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_traffic_request_ctrl.sv
// Scoreboard bench for traffic_request_ctrl: directed scenarios then random button
// bounce and controller phases, checked against a behavioural model.
module tb_traffic_request_ctrl;
  import traffic_pkg::*;

  localparam int unsigned DEB    = 4;
  localparam int unsigned MAXW   = 26;
  localparam int          M_IDLE = 0;
  localparam int          M_PEND = 1;
  localparam int          M_SERV = 2;

  typedef struct packed {
    logic       sw;
    logic       led;
    logic [7:0] cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       btn_raw;
  logic [3:0] q;
  logic       sw;
  logic       led;
  logic [7:0] cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  exp_t exp_q[$];

  // Reference model state
  logic       m_s1, m_s2, m_stable;
  int         m_run;
  int         m_mode;
  logic       m_next;
  int         m_cnt;
  int         m_wait;
  logic [3:0] m_qprev;

  traffic_request_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_WAIT       (MAXW)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .btn_raw    (btn_raw),
    .q          (q),
    .switch     (sw),
    .req_led    (led),
    .press_count(cnt)
  );

  always #5 clock = ~clock;

  // Model of one clock edge given the inputs that edge sampled
  task automatic model_edge(input logic r, input logic b, input logic [3:0] qi);
    logic press;
    exp_t e;
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_run = 0;
      m_mode = M_IDLE; m_next = 0; m_cnt = 0; m_wait = 0; m_qprev = 0;
    end else begin
      press = 0;
      if (m_s2 != m_stable) begin
        m_run = m_run + 1;
        if (m_run == DEB + 1) begin
          m_stable = m_s2;
          m_run    = 0;
          press    = m_stable;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
      if (press && m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_mode == M_IDLE) begin
        if (press) begin
          m_mode = M_PEND; m_wait = 0;
        end
`ifdef TRAFFIC_REQ_TIMEOUT_EN
        else if (m_wait + 1 >= MAXW) begin
          m_mode = M_PEND; m_wait = 0;
        end else begin
          m_wait = m_wait + 1;
        end
`endif
      end else if (m_mode == M_PEND) begin
        m_wait = 0;
        if (m_qprev == 0 && qi != 0) begin
          m_mode = M_SERV;
          m_next = press;
        end
      end else begin
        m_wait = 0;
        if (qi == 0) begin
          m_mode = (m_next || press) ? M_PEND : M_IDLE;
          m_next = 0;
        end else if (press) begin
          m_next = 1;
        end
      end
      m_qprev = qi;
    end
    e.sw  = (m_mode == M_PEND);
    e.led = (m_mode != M_IDLE) || m_next;
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic b, input logic [3:0] qi, input logic r);
    @(negedge clock);
    btn_raw = b;
    q       = qi;
    resetn  = r;
    @(posedge clock);
    cycle = cycle + 1;
    model_edge(r, b, qi);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors = vectors + 1;
    if (got !== want) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors = vectors + 1;
      if (sw !== e.sw || led !== e.led || cnt !== e.cnt) begin
        miscompares = miscompares + 1;
        $display("FAIL scoreboard cycle %0d: got sw=%b led=%b cnt=%0d, want sw=%b led=%b cnt=%0d",
                 cycle, sw, led, cnt, e.sw, e.led, e.cnt);
      end
    end
  end

  initial begin
    int         first_high;
    int         seg_left;
    logic       lvl;
    logic [3:0] qv;
    logic [3:0] qd;
    logic       r;

    btn_raw = 1'b0;
    q       = 4'd0;
    resetn  = 1'b0;

    repeat (2) step(1'b0, 4'd0, 1'b0);
    #1;
    check("reset_switch", 16'(sw), 16'd0);
    check("reset_led", 16'(led), 16'd0);
    check("reset_count", 16'(cnt), 16'd0);

    // Clean press with q held at the hold point
    repeat (6) step(1'b1, 4'd0, 1'b1);
    #1 check("press_latency_low", 16'(sw), 16'd0);
    step(1'b1, 4'd0, 1'b1);
    #1;
    check("press_latency_high", 16'(sw), 16'd1);
    check("press_count_1", 16'(cnt), 16'd1);

    // Release is silent; controller then leaves the hold point
    repeat (10) step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd1, 1'b1);
    #1;
    check("serve_switch_fall", 16'(sw), 16'd0);
    check("serve_led", 16'(led), 16'd1);
    for (int v = 2; v <= 4; v++) step(1'b0, 4'(v), 1'b1);
    for (int v = 5; v <= 12; v++) step(1'b1, 4'(v), 1'b1);
    step(1'b1, 4'd0, 1'b1);
    #1;
    check("next_pending_switch", 16'(sw), 16'd1);
    check("next_press_count", 16'(cnt), 16'd2);

    // Full cycle with no further press returns to IDLE
    repeat (10) step(1'b0, 4'd0, 1'b1);
    for (int v = 1; v <= 12; v++) step(1'b0, 4'(v), 1'b1);
    step(1'b0, 4'd0, 1'b1);
    #1;
    check("cycle_done_led", 16'(led), 16'd0);
    check("cycle_done_switch", 16'(sw), 16'd0);

    // Reset while PENDING with three presses counted
    repeat (7) step(1'b1, 4'd0, 1'b1);
    #1;
    check("third_press_count", 16'(cnt), 16'd3);
    check("third_pending", 16'(sw), 16'd1);
    step(1'b0, 4'd0, 1'b0);
    #1;
    check("midrst_switch", 16'(sw), 16'd0);
    check("midrst_count", 16'(cnt), 16'd0);
    check("midrst_led", 16'(led), 16'd0);

    // Bounce 2 high / 2 low, then settle high
    repeat (5) begin
      repeat (2) step(1'b1, 4'd0, 1'b1);
      repeat (2) step(1'b0, 4'd0, 1'b1);
    end
    repeat (10) step(1'b1, 4'd0, 1'b1);
    #1;
    check("bounce_count", 16'(cnt), 16'd1);
    check("bounce_switch", 16'(sw), 16'd1);

    // Long idle with no press
    step(1'b0, 4'd0, 1'b0);
    first_high = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 4'd0, 1'b1);
      #1;
      if (sw === 1'b1 && first_high == 0) first_high = k;
    end
`ifdef TRAFFIC_REQ_TIMEOUT_EN
    check("timeout_edge", 16'(first_high), 16'(MAXW));
    check("timeout_count", 16'(cnt), 16'd0);
`else
    check("no_timeout", 16'(first_high), 16'd0);
`endif

    // Random button bounce against a stepping controller
    seg_left = 0;
    lvl      = 1'b0;
    qv       = PHASE_HOLD;
    for (int i = 0; i < 4000; i++) begin
      if (seg_left == 0) begin
        lvl      = 1'($urandom_range(0, 1));
        seg_left = $urandom_range(1, 20);
      end
      seg_left = seg_left - 1;
      if (qv == PHASE_HOLD) begin
        if ($urandom_range(0, 5) == 0) qv = 4'd1;
      end else if (qv >= PHASE_LAST) begin
        qv = PHASE_HOLD;
      end else begin
        qv = qv + 4'd1;
      end
      qd = qv;
      if ($urandom_range(0, 49) == 0) qd = 4'($urandom_range(13, 15));
      r = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step(lvl, qd, r);
    end

    @(negedge clock);
    @(negedge clock);
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_request_ctrl.md
# traffic_request_ctrl

Upstream stage of the traffic signal controller. It synchronises and debounces the raw side-street request button and latches one request per light cycle. It drives the controller's `switch` input. It watches the controller's 4-bit mod-13 phase count `q` (0..12, where 0 is the NS-green hold point) to learn when a request has been consumed and when the cycle has finished.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive clocks the synchronised input must differ from the debounced level before the level changes; legal range 1..15.
- `MAX_WAIT`, default 26: idle clocks before an automatic request; used only with the timeout feature; legal range 1..255.

Ports:
- `clock`, input, 1: system clock.
- `resetn`, input, 1: reset, synchronous, active-low.
- `btn_raw`, input, 1: asynchronous request button, active-high, may bounce.
- `q`, input, 4: phase count from the traffic signal controller.
- `switch`, output, 1: request pending to the controller.
- `req_led`, output, 1: "request registered" lamp. High in PENDING and SERVING, and whenever a next request is latched.
- `press_count`, output, 8: count of accepted presses, saturating at 255.

## Operation
- Synchroniser: two flip-flops, `s1` then `s2`.
- Debouncer:
  - 4-bit counter compares `s2` with the debounced level `stable`.
  - If they are equal, the counter clears.
  - If they differ, the counter increments. When it reaches DEBOUNCE_CYCLES, `stable` takes `s2` and the counter clears.
  - An accepted press is a rising edge of `stable`, as a one-clock internal pulse `press`.
- `press_count` increments on every `press`, saturating at 255.
- `q_prev`: `q` registered every clock.
- FSM states:
  - IDLE: `switch`=0.
  - PENDING: `switch`=1.
  - SERVING: `switch`=0.
- Transitions:
  - IDLE → PENDING on `press`.
  - PENDING → SERVING when `q_prev`==0 and `q`!=0, i.e. the controller has left the hold point with the request seen.
  - SERVING → IDLE when `q`==0 and the `next` flag is 0.
  - SERVING → PENDING when `q`==0 and `next`=1. `next` clears on that transition.
- Presses while in PENDING are counted only; the state does not change.
- A press while in SERVING sets `next`.
- Simultaneous events:
  - `press` on the same clock as PENDING → SERVING: the press sets `next`.
  - `press` on the same clock as SERVING → IDLE: the state goes to PENDING.
- Illegal `q` (13..15): treated as nonzero; no special action.

## Timing
- Reset values, applied at the first edge with `resetn`=0:
  - `s1`=0, `s2`=0, `stable`=0, debounce counter=0.
  - `q_prev`=0, `next`=0, wait counter=0.
  - State=IDLE, `switch`=0, `req_led`=0, `press_count`=0.
- Reset mid-operation discards any pending or latched request. A button still held after reset release is re-debounced and accepted as a new press.
- Press latency: `btn_raw` high and stable from before edge t0 gives `switch`=1 after edge t0+DEBOUNCE_CYCLES+2.
  - The `stable` rise and the IDLE → PENDING state change happen on the same edge.
  - `switch`, `req_led` and `press_count` are registered decodes of the state and update on that same edge.
- Release latency is symmetric at DEBOUNCE_CYCLES+2. A release produces no event.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES clocks (after synchronisation) never changes `stable`.
- `switch` falls on the edge where PENDING → SERVING is decided, one clock after the controller leaves `q`=0.

## Configuration
- Macro: `TRAFFIC_REQ_TIMEOUT_EN`.
- When defined:
  - In IDLE, an 8-bit wait counter increments every clock. It clears on leaving IDLE.
  - When the counter reaches MAX_WAIT, the state goes to PENDING and the counter clears. `press_count` is unchanged.
  - A press in IDLE on the same clock also goes to PENDING and is counted.
- When not defined: there is no wait counter, and IDLE is left only by a press.

## Structure
- Shared package `traffic_pkg` holds:
  - the state enum (IDLE, PENDING, SERVING);
  - `PHASE_W`=4;
  - `PHASE_HOLD`=4'd0;
  - `PHASE_LAST`=4'd12.
- Sub-module `btn_debounce` contains the synchroniser, debounce counter and `stable`, and outputs the `press` pulse. The FSM, `next` flag, counters and timeout stay in the top module.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, `q` held at 0: `btn_raw` rises before edge 0 → `switch`=1 after edge 6; `press_count`=1.
- Bounce: pulses of 2 clocks high and 2 clocks low for 20 clocks, then held high → exactly one press; `press_count`=1.
- Service cycle:
  - From PENDING, `q` goes 0→1 → `switch`=0 one clock later and the state is SERVING.
  - `q` steps through 2..12 then 0 → state IDLE, `req_led`=0.
- Press while SERVING (at `q`=5) → on `q` returning to 0 the state is PENDING with `switch`=1. `press_count` increments by 1.
- Reset mid-operation: `resetn`=0 for one edge while PENDING with `press_count`=3 → `switch`=0, `press_count`=0, state IDLE.
- Timeout, with `TRAFFIC_REQ_TIMEOUT_EN` defined and MAX_WAIT=26, no press → `switch`=1 after 26 idle clocks; `press_count` stays 0. Without the macro → `switch` stays 0 for at least 300 clocks.
